// File: rtl/mips_mc_pkg.sv
// -----------------------------------------------------------------------------
// mips_mc_pkg
//   Shared definitions for the multicycle MIPS controller and its datapath:
//   state encoding, supported opcodes, datapath mux/ALU encodings, and the
//   bundled control word driven by the controller.
//   No ports (package).
// -----------------------------------------------------------------------------
package mips_mc_pkg;

    // State encoding is also exported on state_dbg, so values are pinned.
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WR    = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    // Supported opcodes (instruction bits [31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operand B select.
    typedef enum logic [1:0] {
        SRC_B_REG     = 2'b00,  // register B
        SRC_B_FOUR    = 2'b01,  // constant 4
        SRC_B_IMM     = 2'b10,  // sign-extended immediate
        SRC_B_IMM_SH2 = 2'b11   // sign-extended immediate << 2
    } alu_src_b_t;

    // ALU operation class; funct decoding happens in the ALU control.
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    // Next-PC select.
    typedef enum logic [1:0] {
        PC_ALU     = 2'b00,  // ALU result (PC + 4 during fetch)
        PC_ALU_OUT = 2'b01,  // ALUOut (branch target computed in decode)
        PC_JUMP    = 2'b10   // jump target
    } pc_source_t;

    // Full control word, one field per datapath control.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        pc_source_t pc_source;
        logic       illegal_op;
    } ctrl_t;

    // Every control deasserted; each state only raises what it needs.
    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mips_mc_control.sv
// -----------------------------------------------------------------------------
// mips_mc_control
//   Moore control FSM for a multicycle MIPS datapath (lw, sw, R-type, beq, j,
//   addi). Controls are decoded combinationally from the current state; the
//   only input that shapes them is mem_ready (fetch handshake), plus the
//   opcode check that raises illegal_op while in DECODE.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous, active-low reset (forces FETCH)
//   opcode         in   [OP_W] instruction opcode from the IR
//   zero           in   ALU zero flag (unused here; PC write logic qualifies)
//   mem_ready      in   memory access completes this cycle
//   pc_write .. alu_src_a  out  single-bit datapath controls
//   alu_src_b      out  [2] ALU operand B select
//   alu_op         out  [2] ALU operation class
//   pc_source      out  [2] next-PC select
//   illegal_op     out  one-cycle pulse on unsupported opcode
//   state_dbg      out  [4] current state encoding
// -----------------------------------------------------------------------------
module mips_mc_control
    import mips_mc_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_source,
    output logic            illegal_op,
    output logic [3:0]      state_dbg
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;

    // Branch qualification with zero is done at the PC register, so the
    // flag is intentionally not consumed by the controller.
    logic unused_zero;
    assign unused_zero = zero;

    function automatic logic op_is(input logic [OP_W-1:0] op, input logic [5:0] code);
        return op == OP_W'(code);
    endfunction

    // State register; reset takes effect immediately, even mid-stall.
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every bit; no latches.
        state_next = FETCH;
        ctrl       = CTRL_IDLE;

        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_next    = DECODE;
                end else begin
                    state_next = FETCH;
                end
            end

            DECODE: begin
                // Branch target is precomputed here into ALUOut.
                ctrl.alu_src_b = SRC_B_IMM_SH2;
                if (op_is(opcode, OP_LW) || op_is(opcode, OP_SW)) begin
                    state_next = MEM_ADDR;
                end else if (op_is(opcode, OP_RTYPE)) begin
                    state_next = R_EXEC;
                end else if (op_is(opcode, OP_BEQ)) begin
                    state_next = BRANCH;
                end else if (op_is(opcode, OP_J)) begin
                    state_next = JUMP;
                end else if (op_is(opcode, OP_ADDI)) begin
                    state_next = ADDI_EXEC;
                end else begin
                    ctrl.illegal_op = 1'b1;
                    state_next      = FETCH;
                end
            end

            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                if (op_is(opcode, OP_LW)) begin
                    state_next = MEM_RD;
                end else if (op_is(opcode, OP_SW)) begin
                    state_next = MEM_WR;
                end else begin
                    state_next = FETCH;
                end
            end

            MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                state_next    = mem_ready ? MEM_WB : MEM_RD;
            end

            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_next      = FETCH;
            end

            MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                state_next     = mem_ready ? FETCH : MEM_WR;
            end

            R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_FUNCT;
                state_next     = R_WB;
            end

            R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_next     = FETCH;
            end

            BRANCH: begin
                // The PC register gates pc_write_cond with zero.
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_ALU_OUT;
                state_next         = FETCH;
            end

            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_JUMP;
                state_next     = FETCH;
            end

            ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                state_next     = ADDI_WB;
            end

            ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                state_next     = FETCH;
            end

            // Unused encodings: all controls idle, recover through FETCH.
            default: begin
                ctrl       = CTRL_IDLE;
                state_next = FETCH;
            end
        endcase
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = ctrl.illegal_op;
    assign state_dbg     = state;

endmodule

// File: tb/tb_mips_mc_control.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_control
//   Directed bench for mips_mc_control. Inputs change on the falling edge,
//   outputs are sampled 1 time unit later, state advances on the rising edge.
//   Control word layout used for comparison (MSB first):
//   pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
//   mem_to_reg, reg_write, alu_src_a, alu_src_b[2], alu_op[2], pc_source[2],
//   illegal_op.
// -----------------------------------------------------------------------------
module tb_mips_mc_control;
    import mips_mc_pkg::*;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op;
    logic [3:0] state_dbg;

    int errors = 0;
    int checks = 0;

    logic [16:0] ctrl;
    assign ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   reg_dst, mem_to_reg, reg_write, alu_src_a,
                   alu_src_b, alu_op, pc_source, illegal_op};

    // Hand-derived control words per state.
    localparam logic [16:0] C_FETCH_WAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FETCH_RDY  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DECODE     = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_ILLEGAL    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] C_ADDR       = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MEM_RD     = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MEM_WB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_MEM_WR     = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_R_EXEC     = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_R_WB       = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] C_BRANCH     = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_JUMP       = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] C_ADDI_WB    = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

    mips_mc_control #(.OP_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        #1; checks++;
        if (state_dbg !== FETCH || ctrl !== C_FETCH_WAIT) begin
            errors++;
            $display("FAIL reset_idle: state_dbg=%0d ctrl=%b, expected %0d %b", state_dbg, ctrl, FETCH, C_FETCH_WAIT);
        end
        mem_ready = 1'b1;
        #1; checks++;
        if (ctrl !== C_FETCH_RDY) begin
            errors++;
            $display("FAIL reset_ready: ctrl=%b, expected %b", ctrl, C_FETCH_RDY);
        end
        @(negedge clk);
        #1; checks++;
        if (state_dbg !== FETCH) begin
            errors++;
            $display("FAIL reset_hold: state_dbg=%0d, expected %0d", state_dbg, FETCH);
        end
        rst = 1'b1;
    endtask

    // lw with no stalls: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH.
    task automatic test_lw();
        state_t      st [6] = '{FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH};
        logic [16:0] cv [6] = '{C_FETCH_RDY, C_DECODE, C_ADDR, C_MEM_RD, C_MEM_WB, C_FETCH_RDY};
        opcode = 6'b100011; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1; checks++;
            if (state_dbg !== st[i] || ctrl !== cv[i]) begin
                errors++;
                $display("FAIL lw cycle %0d: state_dbg=%0d ctrl=%b, expected %0d %b", i + 1, state_dbg, ctrl, st[i], cv[i]);
            end
            if (i < 5) @(negedge clk);
        end
    endtask

    // sw, R-type, addi back to back: 4-cycle latency each.
    task automatic test_sw_r_addi();
        logic [5:0]  ops [3] = '{6'b101011, 6'b000000, 6'b001000};
        state_t      st [3][5] = '{'{FETCH, DECODE, MEM_ADDR,  MEM_WR,  FETCH},
                                   '{FETCH, DECODE, R_EXEC,    R_WB,    FETCH},
                                   '{FETCH, DECODE, ADDI_EXEC, ADDI_WB, FETCH}};
        logic [16:0] cv [3][5] = '{'{C_FETCH_RDY, C_DECODE, C_ADDR,   C_MEM_WR,  C_FETCH_RDY},
                                   '{C_FETCH_RDY, C_DECODE, C_R_EXEC, C_R_WB,    C_FETCH_RDY},
                                   '{C_FETCH_RDY, C_DECODE, C_ADDR,   C_ADDI_WB, C_FETCH_RDY}};
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k];
            for (int i = 0; i < 5; i++) begin
                #1; checks++;
                if (state_dbg !== st[k][i] || ctrl !== cv[k][i]) begin
                    errors++;
                    $display("FAIL op %b cycle %0d: state_dbg=%0d ctrl=%b, expected %0d %b", ops[k], i + 1, state_dbg, ctrl, st[k][i], cv[k][i]);
                end
                if (i < 4) @(negedge clk);
            end
        end
    endtask

    // beq with zero=1 and zero=0 behaves identically; j likewise 3 cycles.
    task automatic test_branch_jump();
        logic [5:0]  ops [3] = '{6'b000100, 6'b000100, 6'b000010};
        logic        zs  [3] = '{1'b1, 1'b0, 1'b1};
        state_t      st [3][4] = '{'{FETCH, DECODE, BRANCH, FETCH},
                                   '{FETCH, DECODE, BRANCH, FETCH},
                                   '{FETCH, DECODE, JUMP,   FETCH}};
        logic [16:0] cv [3][4] = '{'{C_FETCH_RDY, C_DECODE, C_BRANCH, C_FETCH_RDY},
                                   '{C_FETCH_RDY, C_DECODE, C_BRANCH, C_FETCH_RDY},
                                   '{C_FETCH_RDY, C_DECODE, C_JUMP,   C_FETCH_RDY}};
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k]; zero = zs[k];
            for (int i = 0; i < 4; i++) begin
                #1; checks++;
                if (state_dbg !== st[k][i] || ctrl !== cv[k][i]) begin
                    errors++;
                    $display("FAIL op %b zero=%b cycle %0d: state_dbg=%0d ctrl=%b, expected %0d %b", ops[k], zs[k], i + 1, state_dbg, ctrl, st[k][i], cv[k][i]);
                end
                if (i < 3) @(negedge clk);
            end
        end
        zero = 1'b0;
    endtask

    // Unsupported opcodes: illegal_op pulses in DECODE only, no writes.
    task automatic test_illegal();
        logic [5:0]  ops [2] = '{6'b111111, 6'b101010};
        state_t      st [3]  = '{FETCH, DECODE, FETCH};
        logic [16:0] cv [3]  = '{C_FETCH_RDY, C_ILLEGAL, C_FETCH_RDY};
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            for (int i = 0; i < 3; i++) begin
                #1; checks++;
                if (state_dbg !== st[i] || ctrl !== cv[i]) begin
                    errors++;
                    $display("FAIL illegal %b cycle %0d: state_dbg=%0d ctrl=%b, expected %0d %b", ops[k], i + 1, state_dbg, ctrl, st[i], cv[i]);
                end
                if (i < 2) @(negedge clk);
            end
        end
    endtask

    // Fetch waits 3 cycles; ir_write/pc_write fire once on cycle 4.
    task automatic test_fetch_stall();
        logic        rd [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        state_t      st [7] = '{FETCH, FETCH, FETCH, FETCH, DECODE, JUMP, FETCH};
        logic [16:0] cv [7] = '{C_FETCH_WAIT, C_FETCH_WAIT, C_FETCH_WAIT, C_FETCH_RDY,
                                C_DECODE, C_JUMP, C_FETCH_RDY};
        opcode = 6'b000010;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rd[i];
            #1; checks++;
            if (state_dbg !== st[i] || ctrl !== cv[i]) begin
                errors++;
                $display("FAIL fetch_stall cycle %0d: state_dbg=%0d ctrl=%b, expected %0d %b", i + 1, state_dbg, ctrl, st[i], cv[i]);
            end
            if (i < 6) @(negedge clk);
        end
    endtask

    // Data-memory stalls on lw and sw; mem_ready low elsewhere is ignored.
    task automatic test_mem_stall();
        logic        rd_l [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        state_t      st_l [8] = '{FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_RD, MEM_RD, MEM_WB, FETCH};
        logic [16:0] cv_l [8] = '{C_FETCH_RDY, C_DECODE, C_ADDR, C_MEM_RD, C_MEM_RD, C_MEM_RD,
                                  C_MEM_WB, C_FETCH_RDY};
        logic        rd_s [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        state_t      st_s [6] = '{FETCH, DECODE, MEM_ADDR, MEM_WR, MEM_WR, FETCH};
        logic [16:0] cv_s [6] = '{C_FETCH_RDY, C_DECODE, C_ADDR, C_MEM_WR, C_MEM_WR, C_FETCH_RDY};
        opcode = 6'b100011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rd_l[i];
            #1; checks++;
            if (state_dbg !== st_l[i] || ctrl !== cv_l[i]) begin
                errors++;
                $display("FAIL lw_stall cycle %0d: state_dbg=%0d ctrl=%b, expected %0d %b", i + 1, state_dbg, ctrl, st_l[i], cv_l[i]);
            end
            if (i < 7) @(negedge clk);
        end
        opcode = 6'b101011;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rd_s[i];
            #1; checks++;
            if (state_dbg !== st_s[i] || ctrl !== cv_s[i]) begin
                errors++;
                $display("FAIL sw_stall cycle %0d: state_dbg=%0d ctrl=%b, expected %0d %b", i + 1, state_dbg, ctrl, st_s[i], cv_s[i]);
            end
            if (i < 5) @(negedge clk);
        end
    endtask

    // Reset during a MEM_WR stall aborts the store at once; sw then restarts.
    task automatic test_reset_mid_stall();
        logic        rd [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        state_t      st [5] = '{FETCH, DECODE, MEM_ADDR, MEM_WR, MEM_WR};
        state_t      st2 [5] = '{FETCH, DECODE, MEM_ADDR, MEM_WR, FETCH};
        logic [16:0] cv2 [5] = '{C_FETCH_RDY, C_DECODE, C_ADDR, C_MEM_WR, C_FETCH_RDY};
        opcode = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rd[i];
            #1; checks++;
            if (state_dbg !== st[i]) begin
                errors++;
                $display("FAIL pre_reset cycle %0d: state_dbg=%0d, expected %0d", i + 1, state_dbg, st[i]);
            end
            if (i < 4) @(negedge clk);
        end
        #1; rst = 1'b0;
        #1; checks++;
        if (state_dbg !== FETCH || mem_write !== 1'b0 || ctrl !== C_FETCH_WAIT) begin
            errors++;
            $display("FAIL reset_in_stall: state_dbg=%0d mem_write=%b ctrl=%b, expected %0d 0 %b", state_dbg, mem_write, ctrl, FETCH, C_FETCH_WAIT);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1;
            #1; checks++;
            if (state_dbg !== st2[i] || ctrl !== cv2[i]) begin
                errors++;
                $display("FAIL sw_restart cycle %0d: state_dbg=%0d ctrl=%b, expected %0d %b", i + 1, state_dbg, ctrl, st2[i], cv2[i]);
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    // Random opcode/mem_ready walk: exclusive controls never overlap.
    task automatic test_random();
        logic [5:0] legal [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
        int shown = 0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) opcode = legal[$urandom_range(0, 5)];
            else                           opcode = 6'($urandom_range(0, 63));
            #1; checks++;
            if ((mem_read && mem_write) || (pc_write && pc_write_cond) || state_dbg > 4'd11) begin
                errors++;
                if (shown < 5) begin
                    shown++;
                    $display("FAIL exclusivity cycle %0d: mem_read=%b mem_write=%b pc_write=%b pc_write_cond=%b state_dbg=%0d, expected no overlap and a valid state",
                             n, mem_read, mem_write, pc_write, pc_write_cond, state_dbg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_r_addi();
        test_branch_jump();
        test_illegal();
        test_fetch_stall();
        test_mem_stall();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 Parameter OP_W, default 6, opcode field width.
REQ-002 clk  input  1  clock, all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  OP_W  instruction opcode from instruction register.
REQ-005 zero  input  1  ALU zero flag, informational only; the PC register qualifies branches.
REQ-006 mem_ready  input  1  memory access completes this cycle.
REQ-007 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a  output  1 each  datapath controls.
REQ-008 alu_src_b  output  2  00=B, 01=const 4, 10=sign-extended imm, 11=imm<<2.
REQ-009 alu_op  output  2  00=add, 01=sub, 10=decode funct.
REQ-010 pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-011 illegal_op  output  1  one-cycle pulse on unsupported opcode.
REQ-012 state_dbg  output  4  current state encoding.

Function
REQ-013 Moore FSM; outputs are a function of state and mem_ready only.
REQ-014 States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB.
REQ-015 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write assert only when mem_ready=1; stay in FETCH while mem_ready=0.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode: 100011/101011->MEM_ADDR, 000000->R_EXEC, 000100->BRANCH, 000010->JUMP, 001000->ADDI_EXEC, other->FETCH with illegal_op=1 for that cycle.
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; ->MEM_RD for 100011, ->MEM_WR for 101011.
REQ-018 MEM_RD: mem_read=1, iord=1; hold until mem_ready=1, then ->MEM_WB.
REQ-019 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; ->FETCH.
REQ-020 MEM_WR: mem_write=1, iord=1; hold until mem_ready=1, then ->FETCH.
REQ-021 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; ->R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; ->FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; ->FETCH regardless of zero.
REQ-023 JUMP: pc_write=1, pc_source=10; ->FETCH.
REQ-024 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; ->ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; ->FETCH.
REQ-025 Every output not listed for a state is 0 in that state.
REQ-026 mem_read and mem_write never both 1; pc_write and pc_write_cond never both 1.
REQ-027 Latencies with mem_ready=1: lw 5 cycles, sw/R/addi 4, beq/j 3, illegal 2.
REQ-028 Unreachable state encodings return to FETCH next cycle with all outputs 0.

Reset
REQ-029 rst=0 forces FETCH immediately, mid-instruction or mid-stall; all outputs 0 except FETCH outputs defined by REQ-015.
REQ-030 First FETCH after rst release completes on first cycle with mem_ready=1.

Structure
REQ-031 State enum, opcode constants, alu_src_b/alu_op/pc_source encodings in package mips_mc_pkg, shared with the datapath.
REQ-032 No sub-module; single file with separate state register and combinational next-state/output logic.

Verification
REQ-033 lw (100011), mem_ready=1 -> states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; reg_write=1 and mem_to_reg=1 in cycle 5; back in FETCH cycle 6.
REQ-034 FETCH with mem_ready=0 for 3 cycles, then 1 -> ir_write/pc_write low 3 cycles, high exactly once on cycle 4, DECODE on cycle 5.
REQ-035 beq (000100), zero=1 and zero=0 -> BRANCH shows pc_write_cond=1, pc_source=01, alu_op=01, pc_write=0 in both cases.
REQ-036 opcode 111111 -> illegal_op=1 one cycle in DECODE, FETCH next, no reg_write/mem_write asserted.
REQ-037 rst=0 during MEM_WR stall -> state_dbg=FETCH same cycle, mem_write=0; after release sw restarts from FETCH.
REQ-038 Random opcode/mem_ready run 10k cycles -> REQ-026 exclusivity holds every cycle.
